pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32 core.
- Combines these stall and flush sources into per-stage write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM:
  - load-use hazard (ID vs EX)
  - taken-branch flush
  - data-memory wait
  - multi-cycle divide occupancy in EX
- Sits beside the hazard/forwarding logic in the control directory.
- Also keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- DIV_CYCLES, 4: number of cycles the pipeline front end is frozen for a divide; must be >= 1.
- CNT_W, 32: width of stall_count.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_id_rs1_addr  input  5  rs1 of instruction in ID
- if_id_rs2_addr  input  5  rs2 of instruction in ID
- id_ex_rd_addr  input  5  rd of instruction in EX
- id_ex_mem_read  input  1  instruction in EX is a load
- ex_branch_taken  input  1  branch/jump in EX resolved taken
- ex_is_div  input  1  instruction in EX is DIV/DIVU/REM/REMU
- mem_req  input  1  instruction in MEM accesses data memory
- mem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- id_ex_write  output  1  ID/EX register enable
- ex_mem_write  output  1  EX/MEM register enable
- if_id_flush  output  1  load NOP into IF/ID
- id_ex_flush  output  1  load NOP into ID/EX
- ex_mem_flush  output  1  load NOP into EX/MEM
- div_busy  output  1  divide occupying EX
- stall_count  output  CNT_W  cycles with pc_write=0

Behaviour:
- Reset (async, rst=1):
  - state=RUN, div counter=0, stall_count=0.
  - All *_write=0, all *_flush=1, div_busy=0.
- Outputs are combinational from state and inputs (Mealy); state, counter and stall_count are registered.
- FREEZE means: pc_write=if_id_write=id_ex_write=ex_mem_write=0, all flushes 0.
- NORMAL means: all *_write=1, all flushes 0.
- Load-use condition LU = id_ex_mem_read & (id_ex_rd_addr!=0) & (id_ex_rd_addr==if_id_rs1_addr | id_ex_rd_addr==if_id_rs2_addr).
- RUN rules, evaluated in priority order (first match wins):
  1. mem_req & !mem_ready: FREEZE; next MEM_WAIT.
  2. ex_is_div: FREEZE; load cnt=DIV_CYCLES-1; div_busy=1; next DIV_WAIT.
  3. ex_branch_taken: NORMAL plus if_id_flush=1 and id_ex_flush=1; LU is ignored.
  4. LU: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1. A single bubble is inserted; no state change.
  5. Otherwise: NORMAL.
- MEM_WAIT:
  - mem_ready=0: FREEZE; stay.
  - mem_ready=1: apply RUN rules 2-5 this cycle, with next state as RUN would choose (RUN or DIV_WAIT).
- DIV_WAIT (div_busy=1 throughout):
  - cnt!=0: FREEZE except ex_mem_flush=1 and ex_mem_write=1, so a bubble enters MEM. Decrement cnt.
  - cnt==0 and !(mem_req & !mem_ready): release. NORMAL; ex_is_div, ex_branch_taken and LU are evaluated as RUN rules 3-5, but rule 2 is masked so the divide retires. Next RUN.
  - cnt==0 and mem stall: FREEZE; stay until mem_ready.
- Timing: a divide stays in EX for DIV_CYCLES+1 cycles, with pc_write low for DIV_CYCLES cycles. With DIV_CYCLES=1, the cycle after detection is the release cycle.
- stall_count:
  - Increments on each rising edge with rst=0 and pc_write=0.
  - Saturates at all-ones (no wrap).
- Simultaneous events: priority mem > div > branch > load-use, as listed above.
- Reset mid-divide or mid-wait: immediate return to RUN, counter cleared, no residual div_busy.

Test Plan:
- Reset then idle inputs:
  - During rst=1: writes=0, flushes=1, stall_count=0.
  - After release: NORMAL every cycle, stall_count stays 0.
- id_ex_mem_read=1, rd=5, rs1=5:
  - One cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_count becomes 1.
  - Same stimulus with rd=0: no stall.
- ex_branch_taken=1 with LU also true:
  - if_id_flush=id_ex_flush=1, pc_write=1; no stall counted.
- DIV_CYCLES=4, ex_is_div held high:
  - pc_write low for exactly 4 cycles; div_busy high for 5 cycles.
  - ex_mem_flush=1 on DIV_WAIT cycles 1-3.
  - 5th cycle NORMAL; stall_count=4.
- mem_req=1, mem_ready=0 for 3 cycles then 1:
  - FREEZE for 3 cycles, NORMAL on the 4th; stall_count=3.
  - A simultaneous ex_is_div in the ready cycle enters DIV_WAIT.
- rst asserted during DIV_WAIT with cnt=2:
  - Immediate reset outputs; after release, state RUN, div_busy=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: merges load-use, branch flush, data-memory wait and divide
// occupancy into per-stage write/flush controls, plus a saturating stall counter.
//
// state    | meaning
// RUN      | normal issue; stalls and flushes decided from current inputs
// MEM_WAIT | data-memory access outstanding; front end frozen until mem_ready
// DIV_WAIT | divide occupying EX; bubbles fed to MEM until cnt reaches zero
module pipeline_stall_ctrl #(
    parameter int DIV_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1_addr,
    input  logic [4:0]       if_id_rs2_addr,
    input  logic [4:0]       id_ex_rd_addr,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_is_div,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DCW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DIV_WAIT} state_t;

    state_t         state, state_nxt;
    logic [DCW-1:0] cnt, cnt_nxt;
    logic           lu;
    logic           mem_hold;

    assign lu = id_ex_mem_read && (id_ex_rd_addr != 5'd0) &&
                ((id_ex_rd_addr == if_id_rs1_addr) || (id_ex_rd_addr == if_id_rs2_addr));

    // Once waiting on memory, only mem_ready matters; from RUN the request must be live.
    assign mem_hold = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        div_busy     = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_nxt    = RUN;
            cnt_nxt      = '0;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_hold) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        state_nxt    = MEM_WAIT;
                    end else if (ex_is_div) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        div_busy     = 1'b1;
                        cnt_nxt      = DCW'(DIV_CYCLES - 1);
                        state_nxt    = DIV_WAIT;
                    end else begin
                        state_nxt = RUN;
                        if (ex_branch_taken) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (lu) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                DIV_WAIT: begin
                    div_busy = 1'b1;
                    if (cnt != '0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        cnt_nxt      = cnt - DCW'(1);
                    end else if (mem_req && !mem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                    end else begin
                        // Release: divide retires, so ex_is_div is ignored here.
                        state_nxt = RUN;
                        if (ex_branch_taken) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (lu) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default instance plus a DIV_CYCLES=1,
// CNT_W=2 instance for the short-divide and counter-saturation corners.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] if_id_rs1_addr, if_id_rs2_addr, id_ex_rd_addr;
    logic id_ex_mem_read, ex_branch_taken, ex_is_div, mem_req, mem_ready;

    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, div_busy;
    logic [31:0] stall_count;

    logic s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write;
    logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_div_busy;
    logic [1:0] s_stall_count;

    logic [7:0] outs, s_outs;
    int checks = 0;
    int errors = 0;

    // Packed order: pc, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, ex_mem_f, div_busy
    localparam logic [7:0] O_RST    = 8'h0E;
    localparam logic [7:0] O_NORMAL = 8'hF0;
    localparam logic [7:0] O_FREEZE = 8'h00;
    localparam logic [7:0] O_LU     = 8'h34;
    localparam logic [7:0] O_BRANCH = 8'hFC;
    localparam logic [7:0] O_DIVDET = 8'h01;
    localparam logic [7:0] O_DIVBUB = 8'h13;
    localparam logic [7:0] O_DIVREL = 8'hF1;

    always #5 clk = ~clk;

    assign outs   = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                     if_id_flush, id_ex_flush, ex_mem_flush, div_busy};
    assign s_outs = {s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write,
                     s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_div_busy};

    pipeline_stall_ctrl dut (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr(if_id_rs1_addr), .if_id_rs2_addr(if_id_rs2_addr),
        .id_ex_rd_addr(id_ex_rd_addr), .id_ex_mem_read(id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_is_div(ex_is_div),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .div_busy(div_busy),
        .stall_count(stall_count)
    );

    pipeline_stall_ctrl #(.DIV_CYCLES(1), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr(if_id_rs1_addr), .if_id_rs2_addr(if_id_rs2_addr),
        .id_ex_rd_addr(id_ex_rd_addr), .id_ex_mem_read(id_ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_is_div(ex_is_div),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .id_ex_write(s_id_ex_write), .ex_mem_write(s_ex_mem_write),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .div_busy(s_div_busy),
        .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_id_rs1_addr  = 5'd0;
        if_id_rs2_addr  = 5'd0;
        id_ex_rd_addr   = 5'd0;
        id_ex_mem_read  = 1'b0;
        ex_branch_taken = 1'b0;
        ex_is_div       = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
    task automatic step(input string tag, input logic [7:0] exp);
        #2;
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        #2;
        chk("rst_outs", {24'd0, outs}, {24'd0, O_RST});
        chk("rst_count", stall_count, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 3; i++) step("idle_normal", O_NORMAL);
        chk("idle_count", stall_count, 32'd0);

        id_ex_mem_read = 1'b1; id_ex_rd_addr = 5'd5; if_id_rs1_addr = 5'd5;
        step("lu_bubble", O_LU);
        chk("lu_count", stall_count, 32'd1);
        id_ex_rd_addr = 5'd0; if_id_rs1_addr = 5'd0;
        step("lu_rd0", O_NORMAL);
        id_ex_rd_addr = 5'd7; if_id_rs2_addr = 5'd7;
        step("lu_rs2", O_LU);
        chk("lu_rs2_count", stall_count, 32'd2);

        ex_branch_taken = 1'b1;
        step("branch_over_lu", O_BRANCH);
        chk("branch_count", stall_count, 32'd2);
        idle();

        ex_is_div = 1'b1;
        step("div_detect", O_DIVDET);
        for (int i = 0; i < 3; i++) step("div_bubble", O_DIVBUB);
        step("div_release", O_DIVREL);
        ex_is_div = 1'b0;
        step("div_after", O_NORMAL);
        chk("div_count", stall_count, 32'd6);

        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mem_freeze", O_FREEZE);
        mem_ready = 1'b1;
        step("mem_ready", O_NORMAL);
        chk("mem_count", stall_count, 32'd9);

        mem_ready = 1'b0;
        step("mem_freeze2", O_FREEZE);
        mem_ready = 1'b1; ex_is_div = 1'b1;
        step("mem_then_div", O_DIVDET);
        mem_req = 1'b0;
        step("div_bubble_cnt3", O_DIVBUB);
        chk("pre_rst_count", stall_count, 32'd12);

        rst = 1'b1;
        #2;
        chk("rst_mid_div_outs", {24'd0, outs}, {24'd0, O_RST});
        chk("rst_mid_div_count", stall_count, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        step("post_rst_run", O_NORMAL);
        chk("post_rst_count", stall_count, 32'd0);

        ex_is_div = 1'b1;
        #2 chk("small_div_detect", {24'd0, s_outs}, {24'd0, O_DIVDET});
        @(posedge clk);
        #3 chk("small_div_release", {24'd0, s_outs}, {24'd0, O_DIVREL});
        @(posedge clk);
        #1 ex_is_div = 1'b0;
        #2 chk("small_after", {24'd0, s_outs}, {24'd0, O_NORMAL});
        chk("small_count1", {30'd0, s_stall_count}, 32'd1);
        @(posedge clk);
        #1 mem_req = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        #1 chk("small_count2", {30'd0, s_stall_count}, 32'd2);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1 chk("small_saturate", {30'd0, s_stall_count}, 32'd3);
        idle();
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
